nx_msg_distributor: RTL and testbench
=====================================

Name: nx_msg_distributor

Overview:
- Sits directly downstream of the message decoder's bypass stream and next to the node's locally emitted message stream.
- Merges the two streams and steers each message, by its 2-bit direction tag, into one of four registered outbound channels: N, E, S, W. These drive the neighbouring nodes' inbound message ports.
- When both sources target the same direction, a per-direction round-robin arbiter chooses between them.

Parameters:
- STREAM_WIDTH, 32, width of one message word.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-low. One clock.
- byp_data_i  in  STREAM_WIDTH  bypass message from decoder.
- byp_dir_i  in  2  bypass target direction (0=N, 1=E, 2=S, 3=W).
- byp_valid_i  in  1  bypass valid.
- byp_ready_o  out  1  bypass accepted this cycle.
- emit_data_i  in  STREAM_WIDTH  locally generated message.
- emit_dir_i  in  2  emit target direction, same encoding as byp_dir_i.
- emit_valid_i  in  1  emit valid.
- emit_ready_o  out  1  emit accepted this cycle.
- out_data_o  out  4*STREAM_WIDTH  per-direction data; slice d is [d*STREAM_WIDTH +: STREAM_WIDTH].
- out_valid_o  out  4  per-direction valid; bit d matches direction code d.
- out_ready_i  in  4  per-direction ready from neighbours.

Behaviour:
- Reset (rst_i low at a clk_i edge):
  - out_valid_o=4'b0, out_data_o=0.
  - All round-robin pointers set to favour bypass.
  - byp_ready_o and emit_ready_o are 0 while rst_i is low.
  - Reset mid-transfer discards all held messages; no partial output.
- Slot model: each direction d has one output register (data, valid).
  - Slot d is free when out_valid_o[d]==0, or when out_valid_o[d] && out_ready_i[d] (drain this cycle).
  - This gives full throughput of one message per direction per cycle.
- Request: source s requests slot d when valid_s && dir_s==d.
- Grant:
  - A source is granted if it requests slot d, slot d is free, and it wins arbitration for d.
  - If only one source requests d, it wins.
  - If both request d, the winner is rr_q[d]: 0 selects bypass, 1 selects emit.
- Pointer update: after a contended grant, rr_q[d] flips to favour the loser. Uncontended grants leave rr_q[d] unchanged.
- Ready outputs: byp_ready_o and emit_ready_o equal their grant, combinationally, from same-cycle valid/dir/out_ready_i.
  - Upstream valid must not depend on ready.
  - The decoder's registered valid satisfies this.
- Different targets: if bypass and emit target different directions, both can be granted in the same cycle.
- Latency: accepted on edge N, visible on out_* after edge N. Exactly one cycle, no combinational path from data inputs to outputs.
- Slot update per direction:
  - Load on grant.
  - Else clear valid on drain (out_valid_o[d] && out_ready_i[d]).
  - Else hold.
  - Drain and load in the same cycle replace the word with no valid bubble.
- Stability: while out_valid_o[d] && !out_ready_i[d], out_data_o slice d is held stable.
- Data: passed unmodified. The block does no decode and no broadcast-decay arithmetic.
- Blocked direction: a full, non-draining slot d stalls only sources targeting d. The other source proceeds if its target is free. Order is preserved within each (source, direction) pair.
- Registered state: 4 data registers, 4 valids, 4 rr bits. No counters or FIFOs beyond these. Target 150–250 lines of RTL.

Test Plan:
- Reset: hold rst_i low 3 cycles with byp_valid_i=1 -> out_valid_o==0, byp_ready_o==0. Release -> first byp word (dir=2, data=0xA5A5_0001) appears on S slice one cycle later, out_valid_o==4'b0100.
- Parallel: byp dir=0 data=0x11, emit dir=3 data=0x22 same cycle, all out_ready_i=1 -> both ready=1. Next cycle out_valid_o==4'b1001, N=0x11, W=0x22.
- Contention and fairness: both sources drive dir=1 continuously for 6 cycles, out_ready_i[1]=1 -> E receives byp, emit, byp, emit, byp, emit. Exactly one ready is high each cycle.
- Backpressure: out_ready_i[2]=0 with S slot holding 0x33, byp dir=2 valid -> byp_ready_o=0, S data stays 0x33. Meanwhile emit dir=0 is accepted. Raise out_ready_i[2] -> byp accepted the same cycle; next cycle S=byp word with out_valid_o[2] never dropping.
- Streaming: byp dir=1 sends 8 words 0..7 back-to-back, out_ready_i[1]=1 -> E outputs 0..7 on consecutive cycles, one cycle delayed, no bubbles.
- Mid-operation reset: with all 4 slots valid and out_ready_i=0, assert rst_i for 1 cycle -> out_valid_o==0 next cycle. rr pointers favour bypass on the first contended grant afterwards.

Source files
------------

// File: rtl/nx_msg_distributor.sv
// nx_msg_distributor
// Merges the decoder bypass stream and the local emit stream into four
// registered outbound channels (N, E, S, W) selected by a 2-bit direction tag.
// Each direction owns one output register; when both sources target the same
// direction, a per-direction round-robin bit decides who goes first.
module nx_msg_distributor #(
  parameter int STREAM_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [STREAM_WIDTH-1:0]   byp_data_i,
  input  logic [1:0]                byp_dir_i,
  input  logic                      byp_valid_i,
  output logic                      byp_ready_o,
  input  logic [STREAM_WIDTH-1:0]   emit_data_i,
  input  logic [1:0]                emit_dir_i,
  input  logic                      emit_valid_i,
  output logic                      emit_ready_o,
  output logic [4*STREAM_WIDTH-1:0] out_data_o,
  output logic [3:0]                out_valid_o,
  input  logic [3:0]                out_ready_i
);

  logic [STREAM_WIDTH-1:0] data_q [4];
  logic [3:0]              valid_q;
  logic [3:0]              rr_q;      // 0 favours bypass, 1 favours emit

  logic [3:0] byp_req;
  logic [3:0] emit_req;
  logic [3:0] slot_free;
  logic [3:0] contend;
  logic [3:0] byp_gnt;
  logic [3:0] emit_gnt;

  // Per-direction request decode, slot availability and arbitration.
  // Grants are masked while in reset so neither source sees a handshake.
  always_comb begin
    byp_req   = '0;
    emit_req  = '0;
    slot_free = '0;
    contend   = '0;
    byp_gnt   = '0;
    emit_gnt  = '0;
    for (int d = 0; d < 4; d++) begin
      byp_req[d]   = byp_valid_i  && (byp_dir_i  == 2'(d));
      emit_req[d]  = emit_valid_i && (emit_dir_i == 2'(d));
      // a draining slot can take a new word in the same cycle
      slot_free[d] = !valid_q[d] || out_ready_i[d];
      contend[d]   = byp_req[d] && emit_req[d];
      byp_gnt[d]   = rst_i && slot_free[d] && byp_req[d]  && (!emit_req[d] || !rr_q[d]);
      emit_gnt[d]  = rst_i && slot_free[d] && emit_req[d] && (!byp_req[d]  ||  rr_q[d]);
    end
  end

  // Each source targets at most one direction, so OR-reducing its grants
  // yields its ready.
  always_comb begin
    byp_ready_o  = |byp_gnt;
    emit_ready_o = |emit_gnt;
  end

  // Output slots and round-robin pointers; load wins over drain so a
  // simultaneous drain+load replaces the word without a valid bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      rr_q    <= '0;
      for (int d = 0; d < 4; d++) begin
        data_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (byp_gnt[d]) begin
          data_q[d]  <= byp_data_i;
          valid_q[d] <= 1'b1;
        end else if (emit_gnt[d]) begin
          data_q[d]  <= emit_data_i;
          valid_q[d] <= 1'b1;
        end else if (valid_q[d] && out_ready_i[d]) begin
          valid_q[d] <= 1'b0;
        end
        // after a contended grant, hand priority to the loser
        if (contend[d] && slot_free[d]) begin
          rr_q[d] <= !rr_q[d];
        end
      end
    end
  end

  // Flatten the per-direction registers onto the output bus.
  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data_o[g*STREAM_WIDTH +: STREAM_WIDTH] = data_q[g];
  end

  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_nx_msg_distributor.sv
// Self-checking bench for nx_msg_distributor: directed scenarios followed by
// a randomized phase, all compared against a message-level reference model.
module tb_nx_msg_distributor;

  localparam int W = 32;

  logic           clk_i;
  logic           rst_i;
  logic [W-1:0]   byp_data_i;
  logic [1:0]     byp_dir_i;
  logic           byp_valid_i;
  logic           byp_ready_o;
  logic [W-1:0]   emit_data_i;
  logic [1:0]     emit_dir_i;
  logic           emit_valid_i;
  logic           emit_ready_o;
  logic [4*W-1:0] out_data_o;
  logic [3:0]     out_valid_o;
  logic [3:0]     out_ready_i;

  int checks = 0;
  int errors = 0;

  // reference model: contents of each outbound channel and who goes next
  bit         m_valid [4];
  logic [W-1:0] m_data [4];
  bit         m_emit_next [4];

  logic obs_br, obs_er;

  nx_msg_distributor #(.STREAM_WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byp_data_i   (byp_data_i),
    .byp_dir_i    (byp_dir_i),
    .byp_valid_i  (byp_valid_i),
    .byp_ready_o  (byp_ready_o),
    .emit_data_i  (emit_data_i),
    .emit_dir_i   (emit_dir_i),
    .emit_valid_i (emit_valid_i),
    .emit_ready_o (emit_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] v;
    for (int d = 0; d < 4; d++) v[d] = m_valid[d];
    return v;
  endfunction

  function automatic logic [4*W-1:0] m_data_vec();
    logic [4*W-1:0] v;
    for (int d = 0; d < 4; d++) v[d*W +: W] = m_data[d];
    return v;
  endfunction

  // Which source should be accepted this cycle, worked out per message.
  task automatic model_ready(output bit eb, output bit ee);
    bit bf, ef;
    eb = 0;
    ee = 0;
    if (rst_i) begin
      bf = !m_valid[byp_dir_i]  || out_ready_i[byp_dir_i];
      ef = !m_valid[emit_dir_i] || out_ready_i[emit_dir_i];
      if (byp_valid_i && emit_valid_i && byp_dir_i == emit_dir_i) begin
        if (bf) begin
          ee = m_emit_next[byp_dir_i];
          eb = !ee;
        end
      end else begin
        eb = byp_valid_i  && bf;
        ee = emit_valid_i && ef;
      end
    end
  endtask

  task automatic model_update(input bit eb, input bit ee);
    if (!rst_i) begin
      for (int d = 0; d < 4; d++) begin
        m_valid[d] = 0;
        m_data[d] = '0;
        m_emit_next[d] = 0;
      end
    end else begin
      for (int d = 0; d < 4; d++)
        if (m_valid[d] && out_ready_i[d]) m_valid[d] = 0;
      if (eb) begin
        m_valid[byp_dir_i] = 1;
        m_data[byp_dir_i]  = byp_data_i;
      end
      if (ee) begin
        m_valid[emit_dir_i] = 1;
        m_data[emit_dir_i]  = emit_data_i;
      end
      if (eb && byp_valid_i && emit_valid_i && byp_dir_i == emit_dir_i)
        m_emit_next[byp_dir_i] = 1;
      else if (ee && byp_valid_i && emit_valid_i && byp_dir_i == emit_dir_i)
        m_emit_next[emit_dir_i] = 0;
    end
  endtask

  // One clock: check readies against the model, clock, then check outputs.
  task automatic step();
    bit eb, ee;
    #1;
    model_ready(eb, ee);
    obs_br = byp_ready_o;
    obs_er = emit_ready_o;
    chk("byp_ready", {127'd0, byp_ready_o}, {127'd0, eb});
    chk("emit_ready", {127'd0, emit_ready_o}, {127'd0, ee});
    @(posedge clk_i);
    model_update(eb, ee);
    #1;
    chk("out_valid", {124'd0, out_valid_o}, {124'd0, m_valid_vec()});
    chk("out_data", out_data_o, m_data_vec());
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      m_valid[d] = 0;
      m_data[d] = '0;
      m_emit_next[d] = 0;
    end

    // reset held 3 cycles with bypass already presenting
    rst_i = 0;
    byp_valid_i = 1; byp_dir_i = 2; byp_data_i = 32'hA5A5_0001;
    emit_valid_i = 0; emit_dir_i = 0; emit_data_i = '0;
    out_ready_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_byp_ready", {127'd0, obs_br}, 128'd0);
      chk("rst_valid", {124'd0, out_valid_o}, 128'd0);
    end
    rst_i = 1;
    step();
    chk("first_valid", {124'd0, out_valid_o}, 128'h4);
    chk("first_s", {96'd0, out_data_o[2*W +: W]}, 128'hA5A5_0001);

    // parallel delivery to different directions
    byp_dir_i = 0; byp_data_i = 32'h11;
    emit_valid_i = 1; emit_dir_i = 3; emit_data_i = 32'h22;
    step();
    chk("par_ready", {126'd0, obs_br, obs_er}, 128'h3);
    chk("par_valid", {124'd0, out_valid_o}, 128'h9);
    chk("par_n", {96'd0, out_data_o[0 +: W]}, 128'h11);
    chk("par_w", {96'd0, out_data_o[3*W +: W]}, 128'h22);

    // contention on E alternates starting with bypass
    byp_dir_i = 1; byp_data_i = 32'hBB;
    emit_dir_i = 1; emit_data_i = 32'hEE;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("one_ready", {127'd0, obs_br ^ obs_er}, 128'd1);
      chk("e_seq", {96'd0, out_data_o[W +: W]}, (i % 2 == 0) ? 128'hBB : 128'hEE);
    end

    // backpressure on S stalls only bypass
    emit_valid_i = 0;
    byp_dir_i = 2; byp_data_i = 32'h33;
    step();
    out_ready_i = 4'b1011;
    byp_data_i = 32'h44;
    emit_valid_i = 1; emit_dir_i = 0; emit_data_i = 32'h55;
    step();
    chk("bp_ready", {126'd0, obs_br, obs_er}, 128'h1);
    chk("bp_s_hold", {96'd0, out_data_o[2*W +: W]}, 128'h33);
    chk("bp_n", {96'd0, out_data_o[0 +: W]}, 128'h55);
    out_ready_i = 4'hF;
    emit_valid_i = 0;
    step();
    chk("bp_release", {127'd0, obs_br}, 128'd1);
    chk("bp_s_new", {96'd0, out_data_o[2*W +: W]}, 128'h44);
    chk("bp_s_valid", {127'd0, out_valid_o[2]}, 128'd1);

    // back-to-back streaming into E
    byp_dir_i = 1;
    for (int i = 0; i < 8; i++) begin
      byp_data_i = i;
      step();
      chk("stream_e", {96'd0, out_data_o[W +: W]}, 128'(i));
      chk("stream_v", {127'd0, out_valid_o[1]}, 128'd1);
    end

    // contended S grant moves its pointer toward emit
    byp_dir_i = 2; byp_data_i = 32'h61;
    emit_valid_i = 1; emit_dir_i = 2; emit_data_i = 32'h62;
    step();
    chk("rr_pre", {126'd0, obs_br, obs_er}, 128'h2);

    // fill all four slots, then reset with nothing draining
    byp_dir_i = 0; emit_dir_i = 1;
    step();
    out_ready_i = 4'h0;
    byp_dir_i = 2; emit_dir_i = 3;
    step();
    chk("full", {124'd0, out_valid_o}, 128'hF);
    byp_valid_i = 0; emit_valid_i = 0;
    rst_i = 0;
    step();
    chk("midrst_valid", {124'd0, out_valid_o}, 128'h0);
    rst_i = 1;
    out_ready_i = 4'hF;
    byp_valid_i = 1; emit_valid_i = 1;
    byp_dir_i = 2; emit_dir_i = 2;
    step();
    chk("rr_after_rst", {126'd0, obs_br, obs_er}, 128'h2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_i        = ($urandom_range(0, 49) != 0);
      byp_valid_i  = $urandom_range(0, 1) == 1;
      byp_dir_i    = 2'($urandom_range(0, 3));
      byp_data_i   = $urandom;
      emit_valid_i = $urandom_range(0, 1) == 1;
      emit_dir_i   = 2'($urandom_range(0, 3));
      emit_data_i  = $urandom;
      out_ready_i  = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
